wheel_tach: RTL and testbench
=============================

// Module: wheel_tach
// PURPOSE
//  Quadrature decoder for the left/right wheel encoders (ELA/ELB, ERA/ERB): the feedback side of the
//  PWM/DIR motor drive path. Per wheel it tracks a signed position count and measures speed as
//  edges per fixed sample window. Outputs feed the controller for closed-loop drive and stall checks.
//  Sits beside motor_driver under top, clocked by sysclk (12 MHz).
// PARAMETERS
//  WINDOW_CYCLES  120000  sysclk cycles per speed sample window (10 ms at 12 MHz)
//  POS_W          16      width of signed position counters (wrap modulo 2^POS_W)
//  SPD_W          12      width of signed speed registers (saturating)
//  INVERT_R       1       1 = negate right-wheel delta (mirror-mounted motor); 0 = as left
// PORTS
//  sysclk     in   1      system clock, 12 MHz
//  rst        in   1      synchronous reset, active-high
//  ela, elb   in   1      left encoder A/B, asynchronous
//  era, erb   in   1      right encoder A/B, asynchronous
//  clr_pos    in   1      1-cycle pulse: zero both position counters
//  err_clr    in   1      1-cycle pulse: clear both sticky error flags
//  pos_l      out  POS_W  left signed position, x4 counts
//  pos_r      out  POS_W  right signed position, x4 counts
//  spd_l      out  SPD_W  left signed edges in last completed window
//  spd_r      out  SPD_W  right signed edges in last completed window
//  spd_valid  out  1      1-cycle strobe: spd_l/spd_r just updated
//  err_l      out  1      sticky: illegal left transition seen
//  err_r      out  1      sticky: illegal right transition seen
// BEHAVIOUR
//  - Reset: all outputs 0; synchronizers, prev-state regs, window counter and accumulators 0;
//    decode is suppressed for the first 3 cycles after rst deasserts (priming: no counts, no errors).
//  - Input path: 2-FF sync per pin -> prev-state reg -> compare. Pin change sampled at edge k is
//    reflected in pos_* after edge k+3.
//  - x4 decode on {A,B} (prev -> cur), Gray order 00->01->11->10->00 = -1 per step; reverse order
//    (00->10->11->01->00, A leads B) = +1. No change = 0. Both bits changed = illegal: delta 0, err set.
//  - Right delta negated when INVERT_R=1, before it reaches position and speed.
//  - Position: pos += delta, two's-complement wrap (0x7FFF +1 -> 0x8000).
//    clr_pos wins over a same-cycle edge: pos = 0, that delta is dropped.
//  - Speed: window counter 0..WINDOW_CYCLES-1. Accumulator acc += delta each cycle.
//    On the last window cycle: spd = sat(acc + delta), acc = 0, spd_valid = 1 on the next cycle
//    with the new spd. An edge in the last window cycle counts in the closing window.
//    Saturation to +/-(2^(SPD_W-1)-1); the accumulator itself saturates, never wraps.
//  - clr_pos does not affect speed accumulation or the window phase.
//  - Errors: err_* set on illegal transition and hold until err_clr or rst.
//    Same-cycle set and err_clr: set wins (flag stays 1).
//  - rst mid-window: window restarts at 0; first spd_valid comes WINDOW_CYCLES cycles after rst drops.
// STRUCTURE
//  - Shared package: decode constants (QUAD_FWD/QUAD_REV/QUAD_ILL) and the 4x4 transition
//    table function quad_delta(prev,cur) -> {ill, signed 2-bit delta}.
//  - One sub-module, quad_channel (sync, prime, decode, position, accumulator, error),
//    instanced for left and right. The window counter and spd_valid live in wheel_tach.
// TESTING
//  1. rst high 5 cycles, then idle with A=B=0 -> all outputs 0, no spd_valid, err_l/err_r = 0.
//  2. Left: 8 forward Gray steps, 1 step / 10 cycles -> pos_l = +8 (each step 3 cycles after the pin
//     change); 8 reverse steps -> pos_l = 0.
//  3. Right, INVERT_R=1: 4 steps in the order that gives left +4 -> pos_r = -4.
//     pos_l at 0x7FFE, +3 steps -> 0x8001.
//  4. WINDOW_CYCLES=1000, 50 forward left steps in window, one of them in the last cycle
//     -> spd_l = 50, spd_valid high exactly 1 cycle; idle next window -> spd_l = 0.
//  5. Toggle ela and elb together -> err_l = 1, pos_l unchanged; err_clr -> 0.
//     err_clr with a same-cycle illegal transition -> err_l stays 1.
//  6. clr_pos on the same cycle as a forward step -> pos_l = 0, but the step counts in spd_l.
//     rst at window cycle 500 -> no spd_valid until 1000 cycles after rst drops.

Source files
------------

// File: rtl/wheel_tach_pkg.sv
// Shared quadrature decode definitions for the wheel tachometer.
// quad_delta maps a {A,B} prev->cur pair to a step of -1/0/+1 or flags it illegal.
package wheel_tach_pkg;

    typedef struct packed {
        logic              ill;
        logic signed [1:0] delta;
    } quad_dec_t;

    localparam quad_dec_t QUAD_NONE = 3'b0_00;
    localparam quad_dec_t QUAD_FWD  = 3'b0_01;
    localparam quad_dec_t QUAD_REV  = 3'b0_11;
    localparam quad_dec_t QUAD_ILL  = 3'b1_00;

    // A leading B (00->10->11->01->00) counts up; the opposite rotation counts down.
    function automatic quad_dec_t quad_delta(input logic [1:0] prev, input logic [1:0] cur);
        quad_dec_t r;
        case ({prev, cur})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: r = QUAD_FWD;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: r = QUAD_REV;
            4'b0011, 4'b0110, 4'b1001, 4'b1100: r = QUAD_ILL;
            default:                            r = QUAD_NONE;
        endcase
        quad_delta = r;
    endfunction

endpackage

// File: rtl/wheel_tach_channel.sv
// One encoder channel: pin synchronisers, priming, x4 decode, wrapping position,
// saturating window accumulator and sticky illegal-transition flag.
module quad_channel
    import wheel_tach_pkg::*;
#(
    parameter int POS_W  = 16,
    parameter int SPD_W  = 12,
    parameter bit NEGATE = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    a_i,
    input  logic                    b_i,
    input  logic                    clr_pos_i,
    input  logic                    err_clr_i,
    input  logic                    win_last_i,
    output logic signed [POS_W-1:0] pos_o,
    output logic signed [SPD_W-1:0] spd_o,
    output logic                    err_o
);

    localparam logic signed [SPD_W:0] SUM_MAX = {2'b00, {(SPD_W-1){1'b1}}};
    localparam logic signed [SPD_W:0] SUM_MIN = -SUM_MAX;

    function automatic logic signed [SPD_W-1:0] sat_add(input logic signed [SPD_W-1:0] acc,
                                                        input logic signed [1:0]       d);
        logic signed [SPD_W:0] s;
        s = {acc[SPD_W-1], acc} + {{(SPD_W-1){d[1]}}, d};
        if (s > SUM_MAX)      sat_add = SUM_MAX[SPD_W-1:0];
        else if (s < SUM_MIN) sat_add = SUM_MIN[SPD_W-1:0];
        else                  sat_add = s[SPD_W-1:0];
    endfunction

    logic [1:0]              sync1_q, sync2_q, cur_q, prev_q;
    logic [1:0]              prime_q;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic signed [SPD_W-1:0] acc_q, acc_d, spd_q, spd_d;
    logic                    err_q, err_d;
    quad_dec_t               dec;
    logic                    live;
    logic signed [1:0]       delta;
    logic                    ill;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cur_q   <= '0;
            prev_q  <= '0;
            prime_q <= '0;
            pos_q   <= '0;
            acc_q   <= '0;
            spd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= {a_i, b_i};
            sync2_q <= sync1_q;
            cur_q   <= sync2_q;
            prev_q  <= cur_q;
            if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
            pos_q   <= pos_d;
            acc_q   <= acc_d;
            spd_q   <= spd_d;
            err_q   <= err_d;
        end
    end

    // Decode stays muted until the pipeline has refilled after reset.
    always_comb begin
        dec   = quad_delta(prev_q, cur_q);
        live  = (prime_q == 2'd3);
        ill   = live & dec.ill;
        delta = 2'sd0;
        if (live && !dec.ill) delta = NEGATE ? -dec.delta : dec.delta;

        pos_d = clr_pos_i ? '0 : pos_q + {{(POS_W-2){delta[1]}}, delta};

        acc_d = sat_add(acc_q, delta);
        spd_d = spd_q;
        if (win_last_i) begin
            spd_d = acc_d;
            acc_d = '0;
        end

        err_d = err_q;
        if (ill)            err_d = 1'b1;
        else if (err_clr_i) err_d = 1'b0;
    end

    assign pos_o = pos_q;
    assign spd_o = spd_q;
    assign err_o = err_q;

endmodule

// File: rtl/wheel_tach.sv
// Left/right wheel quadrature tachometer: per-wheel position and windowed speed.
// The shared window counter lives here and strobes both channels on its last cycle.
module wheel_tach
    import wheel_tach_pkg::*;
#(
    parameter int WINDOW_CYCLES = 120000,
    parameter int POS_W         = 16,
    parameter int SPD_W         = 12,
    parameter int INVERT_R      = 1
) (
    input  logic                    sysclk,
    input  logic                    rst,
    input  logic                    ela,
    input  logic                    elb,
    input  logic                    era,
    input  logic                    erb,
    input  logic                    clr_pos,
    input  logic                    err_clr,
    output logic signed [POS_W-1:0] pos_l,
    output logic signed [POS_W-1:0] pos_r,
    output logic signed [SPD_W-1:0] spd_l,
    output logic signed [SPD_W-1:0] spd_r,
    output logic                    spd_valid,
    output logic                    err_l,
    output logic                    err_r
);

    localparam int CNT_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);

    logic [CNT_W-1:0] win_q, win_d;
    logic             vld_q;
    logic             win_last;

    assign win_last = (win_q == WIN_LAST);
    assign win_d    = win_last ? '0 : win_q + CNT_W'(1);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            win_q <= '0;
            vld_q <= 1'b0;
        end else begin
            win_q <= win_d;
            vld_q <= win_last;
        end
    end

    assign spd_valid = vld_q;

    quad_channel #(.POS_W(POS_W), .SPD_W(SPD_W), .NEGATE(1'b0)) u_left (
        .clk_i     (sysclk),
        .rst_i     (rst),
        .a_i       (ela),
        .b_i       (elb),
        .clr_pos_i (clr_pos),
        .err_clr_i (err_clr),
        .win_last_i(win_last),
        .pos_o     (pos_l),
        .spd_o     (spd_l),
        .err_o     (err_l)
    );

    // The right motor is mirror-mounted, so its sense can be flipped.
    quad_channel #(.POS_W(POS_W), .SPD_W(SPD_W), .NEGATE(INVERT_R != 0)) u_right (
        .clk_i     (sysclk),
        .rst_i     (rst),
        .a_i       (era),
        .b_i       (erb),
        .clr_pos_i (clr_pos),
        .err_clr_i (err_clr),
        .win_last_i(win_last),
        .pos_o     (pos_r),
        .spd_o     (spd_r),
        .err_o     (err_r)
    );

endmodule

// File: tb/tb_wheel_tach.sv
// Bench for wheel_tach: event-level reference model plus a spd_valid-driven scoreboard.
module tb_wheel_tach;

    localparam int W     = 1000;
    localparam int POS_W = 16;
    localparam int SPD_W = 10;
    localparam int SMAX  = (1 << (SPD_W - 1)) - 1;
    localparam int INV_R = 1;

    logic sysclk = 1'b0;
    logic rst = 1'b1;
    logic ela = 1'b0, elb = 1'b0, era = 1'b0, erb = 1'b0;
    logic clr_pos = 1'b0, err_clr = 1'b0;
    logic signed [POS_W-1:0] pos_l, pos_r;
    logic signed [SPD_W-1:0] spd_l, spd_r;
    logic spd_valid, err_l, err_r;

    wheel_tach #(.WINDOW_CYCLES(W), .POS_W(POS_W), .SPD_W(SPD_W), .INVERT_R(INV_R)) dut (
        .sysclk(sysclk), .rst(rst), .ela(ela), .elb(elb), .era(era), .erb(erb),
        .clr_pos(clr_pos), .err_clr(err_clr), .pos_l(pos_l), .pos_r(pos_r),
        .spd_l(spd_l), .spd_r(spd_r), .spd_valid(spd_valid), .err_l(err_l), .err_r(err_r)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: events keyed by the rising-edge index (since reset) at which they take effect.
    typedef struct {int l; int r;} spd_t;
    spd_t exp_q[$];
    int   ecnt = 0;
    int   pend_l[int], pend_r[int];
    bit   ill_l[int], ill_r[int], clr_at[int], eclr_at[int];
    logic signed [POS_W-1:0] m_pos_l = '0, m_pos_r = '0;
    int   acc_l = 0, acc_r = 0;
    bit   m_err_l = 1'b0, m_err_r = 1'b0;
    logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int   li = 0, ri = 0;

    function automatic int clamp(input int v);
        if (v > SMAX) return SMAX;
        if (v < -SMAX) return -SMAX;
        return v;
    endfunction

    task automatic model_edge();
        int dl, dr;
        spd_t s;
        if (rst) begin
            ecnt = 0; m_pos_l = '0; m_pos_r = '0; acc_l = 0; acc_r = 0;
            m_err_l = 1'b0; m_err_r = 1'b0;
            pend_l.delete(); pend_r.delete(); ill_l.delete(); ill_r.delete();
            clr_at.delete(); eclr_at.delete(); exp_q.delete();
            return;
        end
        dl = pend_l.exists(ecnt) ? pend_l[ecnt] : 0;
        dr = pend_r.exists(ecnt) ? pend_r[ecnt] : 0;
        if (clr_at.exists(ecnt)) begin
            m_pos_l = '0; m_pos_r = '0;
        end else begin
            m_pos_l = m_pos_l + POS_W'(dl);
            m_pos_r = m_pos_r + POS_W'(dr);
        end
        acc_l = clamp(acc_l + dl);
        acc_r = clamp(acc_r + dr);
        if (ecnt % W == W - 1) begin
            s.l = acc_l; s.r = acc_r;
            exp_q.push_back(s);
            acc_l = 0; acc_r = 0;
        end
        if (ill_l.exists(ecnt)) m_err_l = 1'b1; else if (eclr_at.exists(ecnt)) m_err_l = 1'b0;
        if (ill_r.exists(ecnt)) m_err_r = 1'b1; else if (eclr_at.exists(ecnt)) m_err_r = 1'b0;
        ecnt++;
    endtask

    initial forever begin
        @(posedge sysclk);
        model_edge();
    end

    // Monitor: continuous output comparison and scoreboard pop on spd_valid.
    initial begin
        spd_t e;
        @(posedge sysclk);
        forever begin
            @(negedge sysclk);
            chk("pos_l", $signed(pos_l), $signed(m_pos_l));
            chk("pos_r", $signed(pos_r), $signed(m_pos_r));
            chk("err_l", {31'd0, err_l}, {31'd0, m_err_l});
            chk("err_r", {31'd0, err_r}, {31'd0, m_err_r});
            if (spd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spd_valid_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("spd_l", $signed(spd_l), e.l);
                    chk("spd_r", $signed(spd_r), e.r);
                end
            end else if (exp_q.size() != 0) begin
                chk("spd_valid_missing", {31'd0, spd_valid}, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    // Call right after a falling edge: the pin change is sampled at rising edge ecnt.
    task automatic step(input bit right, input int dir);
        int k, oi, ni, q, d;
        k  = ecnt;
        oi = right ? ri : li;
        ni = (oi + dir + 4) % 4;
        q  = (ni - oi + 4) % 4;
        d  = (q == 1) ? 1 : (q == 3) ? -1 : 0;
        if (right) begin
            if (INV_R != 0) d = -d;
            if (q == 2) ill_r[k+3] = 1'b1;
            pend_r[k+3] = d;
            ri = ni;
            {era, erb} = gray[ni];
        end else begin
            if (q == 2) ill_l[k+3] = 1'b1;
            pend_l[k+3] = d;
            li = ni;
            {ela, elb} = gray[ni];
        end
    endtask

    task automatic wait_edge(input int e);
        int guard = 0;
        while (ecnt < e && guard < 100000) begin
            @(negedge sysclk);
            guard++;
        end
        if (ecnt != e) chk("wait_edge", ecnt, e);
    endtask

    task automatic pulse_clr_pos();
        clr_at[ecnt] = 1'b1;
        clr_pos = 1'b1;
        @(negedge sysclk);
        clr_pos = 1'b0;
    endtask

    task automatic pulse_err_clr();
        eclr_at[ecnt] = 1'b1;
        err_clr = 1'b1;
        @(negedge sysclk);
        err_clr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, k, seen, gap;
        // Reset and idle
        repeat (5) @(negedge sysclk);
        chk("rst_pos_l", $signed(pos_l), 0);
        chk("rst_spd_valid", {31'd0, spd_valid}, 0);
        chk("rst_err_l", {31'd0, err_l}, 0);
        rst = 1'b0;
        repeat (30) @(negedge sysclk);
        chk("idle_pos_l", $signed(pos_l), 0);
        chk("idle_pos_r", $signed(pos_r), 0);

        // Left forward then reverse, random gaps of at least 4 cycles
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1);
            gap = 4 + $urandom_range(0, 8);
            repeat (gap) @(negedge sysclk);
        end
        chk("fwd8_pos_l", $signed(pos_l), 8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, -1);
            repeat (10) @(negedge sysclk);
        end
        chk("rev8_pos_l", $signed(pos_l), 0);

        // Right inverted: left-positive rotation gives a negative count
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1);
            repeat (10) @(negedge sysclk);
        end
        chk("inv_pos_r", $signed(pos_r), -4);

        // Drive left to 0x7FFE at one step per cycle, then across the wrap
        for (int i = 0; i < 32766; i++) begin
            step(1'b0, 1);
            @(negedge sysclk);
        end
        repeat (6) @(negedge sysclk);
        chk("pre_wrap_pos_l", $signed(pos_l), 32'sh7FFE);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1);
            repeat (5) @(negedge sysclk);
        end
        chk("wrap_pos_l", $signed(pos_l), -32'sd32767);

        // 50 forward steps in one window, the last landing on its final cycle
        b = ((ecnt + 20) / W + 1) * W;
        for (int i = 0; i < 49; i++) begin
            wait_edge(b - 3 + 20 * i);
            step(1'b0, 1);
        end
        wait_edge(b + W - 1 - 3);
        step(1'b0, 1);
        wait_edge(b + W);
        chk("win_spd_valid", {31'd0, spd_valid}, 1);
        chk("win_spd_l", $signed(spd_l), 50);
        @(negedge sysclk);
        chk("win_spd_valid_1cyc", {31'd0, spd_valid}, 0);
        wait_edge(b + 2 * W);
        chk("idle_spd_l", $signed(spd_l), 0);

        // Illegal transitions and error clearing
        step(1'b0, 2);
        repeat (8) @(negedge sysclk);
        chk("ill_err_l", {31'd0, err_l}, 1);
        pulse_err_clr();
        repeat (2) @(negedge sysclk);
        chk("clr_err_l", {31'd0, err_l}, 0);
        k = ecnt;
        step(1'b0, 2);
        wait_edge(k + 3);
        pulse_err_clr();
        repeat (2) @(negedge sysclk);
        chk("set_wins_err_l", {31'd0, err_l}, 1);
        step(1'b1, 2);
        repeat (6) @(negedge sysclk);
        step(1'b1, 2);
        repeat (6) @(negedge sysclk);
        pulse_err_clr();
        repeat (3) @(negedge sysclk);

        // clr_pos coincident with a step: position zeroed, step still in the speed window
        while (li != 3) begin
            step(1'b0, 1);
            repeat (5) @(negedge sysclk);
        end
        k = ecnt;
        step(1'b0, 1);
        wait_edge(k + 3);
        pulse_clr_pos();
        repeat (3) @(negedge sysclk);
        chk("clr_pos_l", $signed(pos_l), 0);
        chk("clr_pos_r", $signed(pos_r), 0);
        for (int i = 0; i < 12; i++) begin
            step($urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? 1 : -1);
            repeat (4 + $urandom_range(0, 6)) @(negedge sysclk);
        end
        while (li != 0) begin step(1'b0, 1); repeat (5) @(negedge sysclk); end
        while (ri != 0) begin step(1'b1, 1); repeat (5) @(negedge sysclk); end
        repeat (10) @(negedge sysclk);

        // Reset in mid-window restarts the window phase
        wait_edge(((ecnt + 10) / W + 1) * W + 500);
        rst = 1'b1;
        repeat (2) @(negedge sysclk);
        rst = 1'b0;
        seen = 0;
        repeat (W - 1) begin
            @(negedge sysclk);
            if (spd_valid === 1'b1) seen++;
        end
        chk("rst_no_early_valid", seen, 0);
        @(negedge sysclk);
        chk("rst_first_valid", {31'd0, spd_valid}, 1);
        chk("rst_first_spd_l", $signed(spd_l), 0);
        repeat (20) @(negedge sysclk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
